mz_ps2_keymatrix: RTL and testbench
===================================

# mz_ps2_keymatrix

PS/2 keyboard front end for the MZ-80 core. It deserialises PS/2 frames and translates set-2 make/break codes into the 10-row × 8-column MZ-80 key matrix. It then returns the active-low row selected by the CPU's keyboard strobe (the low nibble latched on writes to E000h). Its output feeds the E001h read path of the CPU data mux directly.

## Interface
Parameters:
- TIMEOUT_CYCLES, 100000: idle clocks (2 ms) after which a partial frame is discarded.
- ROWS, 10: number of matrix rows; strobe values ≥ ROWS read as no keys pressed.

Ports:
- CLK_50MHZ  in  1  system clock; all logic in this single domain.
- RESET  in  1  reset, asynchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock pad, asynchronous.
- ps2_data  in  1  raw PS/2 data pad, asynchronous.
- key_strobe  in  4  row select from the E000h latch.
- row_data  out  8  selected row, active-low (0 = pressed).
- scan_valid  out  1  one-cycle pulse for each good frame.
- scan_code  out  8  last good frame byte; held until the next good frame.
- frame_err  out  1  one-cycle pulse on a start, parity or stop error, or on timeout.

## Operation
- Input sync: ps2_clk and ps2_data each pass through 2 flip-flops. The block acts on a falling edge of the synchronised ps2_clk, and samples data on that edge.
- Receive FSM:
  - IDLE: on a falling edge, data = 0 → go to DATA with bit count 0. Data = 1 → assert frame_err and stay in IDLE.
  - DATA: shift LSB first. After 8 bits → go to PARITY.
  - PARITY: store the parity bit → go to STOP.
  - STOP: if stop = 1 and odd parity over the 9 bits holds → pulse scan_valid and load scan_code. Otherwise pulse frame_err. Either way → IDLE.
- Timeout: a counter clears on every falling edge. In any state other than IDLE, reaching TIMEOUT_CYCLES-1 → pulse frame_err and go to IDLE.
- Decoder, driven by scan_valid:
  - 0xE0 sets the ext flag.
  - 0xF0 sets the brk flag.
  - 0xAA with brk clear sets all matrix bits to 1.
  - Any other code goes through the map. If it maps, bit[row][col] ← brk (break = 1 = released).
  - Unmapped codes, and every non-prefix code, clear both ext and brk.
  - frame_err also clears ext and brk.
- Map: input {ext, code[7:0]}, output {hit, row[3:0], col[2:0]}. Required entries (full table in package):
  - 0x5A Enter → row 0, col 0
  - 0x1C A → row 4, col 0
  - 0x29 Space → row 6, col 4
  - E0 0x75 Up → row 9, col 2
  - 0x12 LShift → row 8, col 0
- Read: row_data ← matrix[key_strobe] when key_strobe < ROWS, else 8'hFF.

## Timing
- Reset values:
  - row_data = 8'hFF
  - scan_code = 8'h00
  - scan_valid = 0
  - frame_err = 0
  - matrix all 1
  - ext = 0, brk = 0
  - FSM in IDLE
  - timeout counter 0
- Edge detection: a pad falling edge is seen internally 3 clocks later (2 sync flip-flops plus 1 edge register).
- Frame latency: the stop-bit edge is detected at cycle N. scan_valid or frame_err pulses at N+1. The matrix updates at N+2. row_data shows the change at N+3.
- Strobe latency: row_data is registered, so a key_strobe change appears on row_data one clock later.
- Simultaneous events:
  - A matrix write and a read of the same row in the same cycle: row_data shows the pre-write value. The new value appears the next cycle.
  - BAT clear takes priority over any pending ext or brk.
- Asynchronous RESET mid-frame aborts the frame with no error pulse.

## Structure
- Package mz_kbd_pkg holds:
  - localparams ROWS_MAX = 10 and the frame length of 11
  - the FSM state enum (IDLE, DATA, PARITY, STOP)
  - the codes E0, F0 and AA
  - the scan-to-matrix table constants
- Sub-module mz_scan_map: a purely combinational lookup of {ext, code} → {hit, row, col}, kept separate so it can be verified exhaustively.
- The top holds the sync/receive FSM, the timeout counter, the decoder flags, and the 80-bit matrix register with its read mux.

## Test plan
- Frame 0x1C with key_strobe = 4 → scan_valid pulse, scan_code = 0x1C, row_data = 8'hFE. Then F0 1C → row_data = 8'hFF.
- E0 75 → row 9 = 8'hFB. A bare 75 (no E0) leaves every row at 8'hFF.
- Bad parity on 0x5A → frame_err pulse, no scan_valid, row 0 stays 8'hFF. The next good 0x5A → row 0 = 8'hFE.
- Stop clocking after 5 data bits → frame_err exactly TIMEOUT_CYCLES after the last edge. The next full 0x29 frame decodes (row 6 = 8'hEF).
- Press 0x12 and 0x1C, then receive 0xAA → all rows 8'hFF. key_strobe = 12 → row_data = 8'hFF.
- Assert RESET in the middle of an F0 sequence → outputs return to reset values. A following 0x5A is treated as a make (row 0 = 8'hFE).

Source files
------------

// File: rtl/mz_kbd_pkg.sv
// Shared constants for the MZ-80 PS/2 keyboard front end: frame shape,
// receive states, set-2 prefix codes and the scan-code to matrix table.
package mz_kbd_pkg;

  localparam int ROWS_MAX   = 10;
  localparam int FRAME_BITS = 11;  // start + 8 data + parity + stop

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] CODE_BAT = 8'hAA;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
    logic [3:0] row;
    logic [2:0] col;
  } map_entry_t;

  localparam int MAP_N = 53;

  // {ext, set-2 code, matrix row, matrix column}
  localparam map_entry_t MAP_TABLE [MAP_N] = '{
    // row 0: Enter, Backspace, Esc
    '{1'b0, 8'h5A, 4'd0, 3'd0}, '{1'b0, 8'h66, 4'd0, 3'd1}, '{1'b0, 8'h76, 4'd0, 3'd2},
    // row 1: digits 1..8
    '{1'b0, 8'h16, 4'd1, 3'd0}, '{1'b0, 8'h1E, 4'd1, 3'd1}, '{1'b0, 8'h26, 4'd1, 3'd2},
    '{1'b0, 8'h25, 4'd1, 3'd3}, '{1'b0, 8'h2E, 4'd1, 3'd4}, '{1'b0, 8'h36, 4'd1, 3'd5},
    '{1'b0, 8'h3D, 4'd1, 3'd6}, '{1'b0, 8'h3E, 4'd1, 3'd7},
    // row 2: 9 0 - =
    '{1'b0, 8'h46, 4'd2, 3'd0}, '{1'b0, 8'h45, 4'd2, 3'd1}, '{1'b0, 8'h4E, 4'd2, 3'd2},
    '{1'b0, 8'h55, 4'd2, 3'd3},
    // row 3: Q W E R T Y U I
    '{1'b0, 8'h15, 4'd3, 3'd0}, '{1'b0, 8'h1D, 4'd3, 3'd1}, '{1'b0, 8'h24, 4'd3, 3'd2},
    '{1'b0, 8'h2D, 4'd3, 3'd3}, '{1'b0, 8'h2C, 4'd3, 3'd4}, '{1'b0, 8'h35, 4'd3, 3'd5},
    '{1'b0, 8'h3C, 4'd3, 3'd6}, '{1'b0, 8'h43, 4'd3, 3'd7},
    // row 4: A S D F G H J K
    '{1'b0, 8'h1C, 4'd4, 3'd0}, '{1'b0, 8'h1B, 4'd4, 3'd1}, '{1'b0, 8'h23, 4'd4, 3'd2},
    '{1'b0, 8'h2B, 4'd4, 3'd3}, '{1'b0, 8'h34, 4'd4, 3'd4}, '{1'b0, 8'h33, 4'd4, 3'd5},
    '{1'b0, 8'h3B, 4'd4, 3'd6}, '{1'b0, 8'h42, 4'd4, 3'd7},
    // row 5: Z X C V B N M O
    '{1'b0, 8'h1A, 4'd5, 3'd0}, '{1'b0, 8'h22, 4'd5, 3'd1}, '{1'b0, 8'h21, 4'd5, 3'd2},
    '{1'b0, 8'h2A, 4'd5, 3'd3}, '{1'b0, 8'h32, 4'd5, 3'd4}, '{1'b0, 8'h31, 4'd5, 3'd5},
    '{1'b0, 8'h3A, 4'd5, 3'd6}, '{1'b0, 8'h44, 4'd5, 3'd7},
    // row 6: P L , . Space /
    '{1'b0, 8'h4D, 4'd6, 3'd0}, '{1'b0, 8'h4B, 4'd6, 3'd1}, '{1'b0, 8'h41, 4'd6, 3'd2},
    '{1'b0, 8'h49, 4'd6, 3'd3}, '{1'b0, 8'h29, 4'd6, 3'd4}, '{1'b0, 8'h4A, 4'd6, 3'd5},
    // row 8: LShift RShift Ctrl
    '{1'b0, 8'h12, 4'd8, 3'd0}, '{1'b0, 8'h59, 4'd8, 3'd1}, '{1'b0, 8'h14, 4'd8, 3'd2},
    // row 9: extended cursor block
    '{1'b1, 8'h6B, 4'd9, 3'd0}, '{1'b1, 8'h74, 4'd9, 3'd1}, '{1'b1, 8'h75, 4'd9, 3'd2},
    '{1'b1, 8'h72, 4'd9, 3'd3}, '{1'b1, 8'h6C, 4'd9, 3'd4}
  };

endpackage

// File: rtl/mz_scan_map.sv
// Combinational {ext, code} -> {hit, row, col} lookup into the package table.
module mz_scan_map
  import mz_kbd_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output logic       hit,
  output logic [3:0] row,
  output logic [2:0] col
);

  // table scan; entries are unique so at most one matches
  always_comb begin
    hit = 1'b0;
    row = '0;
    col = '0;
    for (int i = 0; i < MAP_N; i++) begin
      if (MAP_TABLE[i].ext == ext && MAP_TABLE[i].code == code) begin
        hit = 1'b1;
        row = MAP_TABLE[i].row;
        col = MAP_TABLE[i].col;
      end
    end
  end

endmodule

// File: rtl/mz_ps2_keymatrix.sv
// PS/2 receiver + set-2 decoder driving the MZ-80 10x8 key matrix, with the
// registered E001h row read (active-low, 0 = pressed).
module mz_ps2_keymatrix
  import mz_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int ROWS           = ROWS_MAX
) (
  input  logic       CLK_50MHZ,
  input  logic       RESET,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [3:0] key_strobe,
  output logic [7:0] row_data,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  localparam int            TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    LAST_DB = 3'(FRAME_BITS - 4);  // index of last data bit

  // pad synchronisers and falling-edge strobe
  logic [1:0]    clk_sync_q, data_sync_q;
  logic          clk_prev_q, fall_q, fall_d, bit_q;

  rx_state_t     st_q, st_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          scan_valid_q, scan_valid_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    scan_code_q, scan_code_d;

  logic                  ext_q, ext_d, brk_q, brk_d;
  logic [ROWS-1:0][7:0]  matrix_q, matrix_d;
  logic [7:0]            row_data_q, row_data_d;

  logic       map_hit;
  logic [3:0] map_row;
  logic [2:0] map_col;

  assign fall_d = clk_prev_q & ~clk_sync_q[1];

  // receive FSM next state: acts only on the registered falling edge
  always_comb begin
    st_d         = st_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    to_cnt_d     = to_cnt_q;
    scan_code_d  = scan_code_q;
    scan_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (fall_q) begin
      to_cnt_d = '0;
      case (st_q)
        IDLE: begin
          if (!bit_q) begin
            st_d      = DATA;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        DATA: begin
          shift_d   = {bit_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_DB) st_d = PARITY;
        end
        PARITY: begin
          par_d = bit_q;
          st_d  = STOP;
        end
        default: begin
          if (bit_q && (^{shift_q, par_q})) begin
            scan_valid_d = 1'b1;
            scan_code_d  = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
          st_d = IDLE;
        end
      endcase
    end else if (st_q != IDLE) begin
      if (to_cnt_q == TO_LAST) begin
        frame_err_d = 1'b1;
        st_d        = IDLE;
        to_cnt_d    = '0;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
  end

  // sync chain, edge strobe and receive registers
  always_ff @(posedge CLK_50MHZ or posedge RESET) begin
    if (RESET) begin
      clk_sync_q   <= 2'b11;
      data_sync_q  <= 2'b11;
      clk_prev_q   <= 1'b1;
      fall_q       <= 1'b0;
      bit_q        <= 1'b1;
      st_q         <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      scan_code_q  <= '0;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], ps2_clk};
      data_sync_q  <= {data_sync_q[0], ps2_data};
      clk_prev_q   <= clk_sync_q[1];
      fall_q       <= fall_d;
      bit_q        <= data_sync_q[1];
      st_q         <= st_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      scan_valid_q <= scan_valid_d;
      frame_err_q  <= frame_err_d;
      scan_code_q  <= scan_code_d;
    end
  end

  mz_scan_map u_map (
    .ext  (ext_q),
    .code (scan_code_q),
    .hit  (map_hit),
    .row  (map_row),
    .col  (map_col)
  );

  // decoder: prefix flags, BAT clear and matrix bit writes (1 = released)
  always_comb begin
    ext_d    = ext_q;
    brk_d    = brk_q;
    matrix_d = matrix_q;
    if (frame_err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (scan_valid_q) begin
      if (scan_code_q == CODE_EXT) begin
        ext_d = 1'b1;
      end else if (scan_code_q == CODE_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (scan_code_q == CODE_BAT && !brk_q)
          matrix_d = '1;
        else if (map_hit && 32'(map_row) < ROWS)
          matrix_d[map_row][map_col] = brk_q;
      end
    end
  end

  // registered row read; reads the pre-write matrix in a same-cycle update
  always_comb begin
    row_data_d = 8'hFF;
    if (32'(key_strobe) < ROWS) row_data_d = matrix_q[key_strobe];
  end

  // decoder state, matrix and read register
  always_ff @(posedge CLK_50MHZ or posedge RESET) begin
    if (RESET) begin
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      matrix_q   <= '1;
      row_data_q <= 8'hFF;
    end else begin
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      matrix_q   <= matrix_d;
      row_data_q <= row_data_d;
    end
  end

  assign row_data   = row_data_q;
  assign scan_valid = scan_valid_q;
  assign scan_code  = scan_code_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_mz_ps2_keymatrix.sv
// Directed bench for mz_ps2_keymatrix: PS/2 frames driven on the pads,
// hand-computed row/latency expectations.
module tb_mz_ps2_keymatrix;

  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [3:0] key_strobe = 4'd4;
  logic [7:0] row_data, scan_code;
  logic       scan_valid, frame_err;

  int n_cmp = 0, n_bad = 0, n_vld = 0, n_err = 0;
  int vld_k, rd_k, err_k, v0, e0;

  mz_ps2_keymatrix #(.TIMEOUT_CYCLES(TO), .ROWS(10)) dut (
    .CLK_50MHZ  (clk),
    .RESET      (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key_strobe (key_strobe),
    .row_data   (row_data),
    .scan_valid (scan_valid),
    .scan_code  (scan_code),
    .frame_err  (frame_err)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (scan_valid) n_vld++;
    if (frame_err)  n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ps2_fall(input logic b);
    @(negedge clk); ps2_data = b;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b0;
  endtask

  task automatic ps2_rise();
    repeat (8) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // full frame; latencies of the stop bit are recorded in negedges after the pad fall
  task automatic send_frame(input logic [7:0] code, input logic bad_par);
    logic [10:0] bits;
    logic [7:0]  rd0;
    bits = {1'b1, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ps2_fall(bits[i]);
      ps2_rise();
    end
    ps2_fall(1'b1);
    rd0 = row_data; vld_k = 0; rd_k = 0; err_k = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 8) ps2_clk = 1'b1;
      if (scan_valid && vld_k == 0) vld_k = k;
      if (frame_err && err_k == 0) err_k = k;
      if (row_data !== rd0 && rd_k == 0) rd_k = k;
    end
  endtask

  task automatic set_strobe(input logic [3:0] s);
    @(negedge clk); key_strobe = s;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_row", row_data, 8'hFF);
    chk("rst_code", scan_code, 8'h00);
    chk("rst_vld", scan_valid, 0);
    chk("rst_err", frame_err, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // make A, then break A
    v0 = n_vld;
    send_frame(8'h1C, 1'b0);
    chk("a_vld_lat", vld_k, 4);
    chk("a_row_lat", rd_k, 6);
    chk("a_vld_cnt", n_vld - v0, 1);
    chk("a_code", scan_code, 8'h1C);
    chk("a_row", row_data, 8'hFE);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    chk("a_release", row_data, 8'hFF);

    // extended Up, release, then bare 75
    set_strobe(4'd9);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    chk("up_make", row_data, 8'hFB);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    chk("up_break", row_data, 8'hFF);
    send_frame(8'h75, 1'b0);
    for (int r = 0; r < 10; r++) begin
      set_strobe(4'(r));
      chk($sformatf("bare75_r%0d", r), row_data, 8'hFF);
    end

    // bad parity on Enter, then good Enter
    set_strobe(4'd0);
    e0 = n_err; v0 = n_vld;
    send_frame(8'h5A, 1'b1);
    chk("bp_err_cnt", n_err - e0, 1);
    chk("bp_err_lat", err_k, 4);
    chk("bp_vld_cnt", n_vld - v0, 0);
    chk("bp_row", row_data, 8'hFF);
    send_frame(8'h5A, 1'b0);
    chk("enter_make", row_data, 8'hFE);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h5A, 1'b0);
    chk("enter_break", row_data, 8'hFF);

    // timeout after start + 5 data bits of 0x29 (LSB first 1,0,0,1,0)
    e0 = n_err;
    ps2_fall(1'b0); ps2_rise();
    ps2_fall(1'b1); ps2_rise();
    ps2_fall(1'b0); ps2_rise();
    ps2_fall(1'b0); ps2_rise();
    ps2_fall(1'b1); ps2_rise();
    ps2_fall(1'b0);
    err_k = 0;
    for (int k = 1; k <= TO + 12; k++) begin
      @(negedge clk);
      if (k == 8) ps2_clk = 1'b1;
      if (frame_err && err_k == 0) err_k = k;
    end
    chk("to_lat", err_k, TO + 4);
    chk("to_cnt", n_err - e0, 1);
    set_strobe(4'd6);
    send_frame(8'h29, 1'b0);
    chk("space_make", row_data, 8'hEF);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h29, 1'b0);

    // LShift + A, strobe latency, then E0 AA clears everything
    set_strobe(4'd8);
    send_frame(8'h12, 1'b0);
    chk("lshift", row_data, 8'hFE);
    set_strobe(4'd4);
    send_frame(8'h1C, 1'b0);
    chk("a_again", row_data, 8'hFE);
    set_strobe(4'd9);
    chk("pre_strobe", row_data, 8'hFF);
    @(negedge clk); key_strobe = 4'd8;
    @(negedge clk);
    chk("strobe_lat", row_data, 8'hFE);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hAA, 1'b0);
    chk("bat_r8", row_data, 8'hFF);
    set_strobe(4'd4);
    chk("bat_r4", row_data, 8'hFF);
    set_strobe(4'd12);
    chk("strobe12", row_data, 8'hFF);

    // reset in the middle of a break sequence
    set_strobe(4'd0);
    send_frame(8'h5A, 1'b0);
    chk("pre_rst_make", row_data, 8'hFE);
    send_frame(8'hF0, 1'b0);
    ps2_fall(1'b0); ps2_rise();
    ps2_fall(1'b0);
    e0 = n_err;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_row", row_data, 8'hFF);
    chk("mid_rst_code", scan_code, 8'h00);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_no_err", n_err - e0, 0);
    send_frame(8'h5A, 1'b0);
    chk("post_rst_make", row_data, 8'hFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
